// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: memory map constants,
// fetch FSM encoding and the PC-to-ROM-word conversion.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // Word index of a byte PC relative to the ROM base; upper bits show overrun.
    function automatic logic [29:0] pc_to_word(input logic [31:0] pc,
                                               input logic [31:0] base);
        return 30'((pc - base) >> 2);
    endfunction

endpackage

// File: rtl/ifid_register.sv
// Pipeline register with flush > stall > load priority; a bubble still
// captures the PC so later stages can attribute it. Reused for ID/EX.
module ifid_register #(
    parameter int                WIDTH  = 32,
    parameter logic [WIDTH-1:0]  BUBBLE = instruction_fetch_unit_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] instruction_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] instruction_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             valid_o
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction_o <= BUBBLE;
            pc_o          <= '0;
            pc_plus4_o    <= '0;
            valid_o       <= 1'b0;
        end else if (flush_i || !stall_i) begin
            pc_o       <= pc_i;
            pc_plus4_o <= pc_i + WIDTH'(4);
            if (load_i && !flush_i) begin
                instruction_o <= instruction_i;
                valid_o       <= 1'b1;
            end else begin
                instruction_o <= BUBBLE;
                valid_o       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC and the FIRST/RUN/HALT fetch FSM, drives the ROM
// word address and feeds the IF/ID register.
module instruction_fetch_unit #(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    ADDR_WIDTH   = $clog2(MEMORY_DEPTH) - 1,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = instruction_fetch_unit_pkg::TEXT_BASE,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = instruction_fetch_unit_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] ifid_instruction_o,
    output logic [DATA_WIDTH-1:0] ifid_pc_o,
    output logic [DATA_WIDTH-1:0] ifid_pc_plus4_o,
    output logic                  ifid_valid_o,
    output logic                  misaligned_o,
    output logic                  out_of_range_o
);

    import instruction_fetch_unit_pkg::*;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] aligned_target;
    logic [29:0]           word_index;
    logic                  misaligned_q;
    logic                  ifid_load;
    logic                  ifid_stall;

    assign word_index     = pc_to_word(pc_q, TEXT_BASE);
    assign address_o      = word_index[ADDR_WIDTH-1:0];
    assign out_of_range_o = (pc_q < TEXT_BASE) || ((word_index >> ADDR_WIDTH) != '0);
    assign aligned_target = {redirect_target_i[DATA_WIDTH-1:2], 2'b00};
    assign pc_o           = pc_q;
    assign misaligned_o   = misaligned_q;

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_stall = stall_i;
        unique case (state_q)
            FIRST: begin
                state_d = RUN;
                if (redirect_i)    pc_d = aligned_target;
                else if (!stall_i) pc_d = pc_q + PC_STEP;
            end
            RUN: begin
                ifid_load = !out_of_range_o;
                if (redirect_i)          pc_d = aligned_target;
                else if (out_of_range_o) state_d = HALT;
                else if (!stall_i)       pc_d = pc_q + PC_STEP;
            end
            HALT: begin
                // Stall is ignored here so the IF/ID keeps emitting bubbles.
                ifid_stall = 1'b0;
                if (redirect_i) begin
                    pc_d    = aligned_target;
                    state_d = RUN;
                end
            end
            default: state_d = FIRST;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FIRST;
            pc_q         <= TEXT_BASE;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= redirect_i && (redirect_target_i[1:0] != 2'b00);
        end
    end

    ifid_register #(
        .WIDTH  (DATA_WIDTH),
        .BUBBLE (NOP_INSTR)
    ) u_ifid (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .stall_i       (ifid_stall),
        .load_i        (ifid_load),
        .instruction_i (instruction_i),
        .pc_i          (pc_q),
        .instruction_o (ifid_instruction_o),
        .pc_o          (ifid_pc_o),
        .pc_plus4_o    (ifid_pc_plus4_o),
        .valid_o       (ifid_valid_o)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural ROM and a
// scoreboard queue of expected per-cycle outputs.
module tb_instruction_fetch_unit;

    localparam logic [31:0] B   = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        chk_pc;
        logic [31:0] pc_o;
        logic        mis;
        logic        oor;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_target_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] instruction_i;
    logic [4:0]  address_o;
    logic [31:0] pc_o;
    logic [31:0] ifid_instruction_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus4_o;
    logic        ifid_valid_o;
    logic        misaligned_o;
    logic        out_of_range_o;

    logic [31:0] rom [32];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always_comb instruction_i = rom[address_o];

    instruction_fetch_unit dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall_i),
        .redirect_i         (redirect_i),
        .redirect_target_i  (redirect_target_i),
        .flush_i            (flush_i),
        .instruction_i      (instruction_i),
        .address_o          (address_o),
        .pc_o               (pc_o),
        .ifid_instruction_o (ifid_instruction_o),
        .ifid_pc_o          (ifid_pc_o),
        .ifid_pc_plus4_o    (ifid_pc_plus4_o),
        .ifid_valid_o       (ifid_valid_o),
        .misaligned_o       (misaligned_o),
        .out_of_range_o     (out_of_range_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected outputs for the coming edge, advance, then compare.
    task automatic step(input logic [31:0] e_instr, input logic [31:0] e_pc,
                        input logic e_valid, input logic e_chk_pc,
                        input logic [31:0] e_pc_o, input logic e_mis,
                        input logic e_oor, input string tag);
        exp_t e;
        e.instr  = e_instr;
        e.pc     = e_pc;
        e.valid  = e_valid;
        e.chk_pc = e_chk_pc;
        e.pc_o   = e_pc_o;
        e.mis    = e_mis;
        e.oor    = e_oor;
        e.tag    = tag;
        exp_q.push_back(e);
        tick();
        e = exp_q.pop_front();
        check({e.tag, ".instr"}, ifid_instruction_o, e.instr);
        check({e.tag, ".valid"}, 32'(ifid_valid_o), 32'(e.valid));
        if (e.chk_pc) begin
            check({e.tag, ".ifid_pc"}, ifid_pc_o, e.pc);
            check({e.tag, ".ifid_pc4"}, ifid_pc_plus4_o, e.pc + 32'd4);
        end
        check({e.tag, ".pc_o"}, pc_o, e.pc_o);
        check({e.tag, ".misaligned"}, 32'(misaligned_o), 32'(e.mis));
        check({e.tag, ".out_of_range"}, 32'(out_of_range_o), 32'(e.oor));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h0000_1000 + 32'(i);
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44; rom[4] = 32'h55;

        // Reset state
        repeat (2) tick();
        check("rst.pc_o", pc_o, B);
        check("rst.instr", ifid_instruction_o, NOP);
        check("rst.valid", 32'(ifid_valid_o), 32'd0);
        check("rst.ifid_pc", ifid_pc_o, 32'd0);
        check("rst.ifid_pc4", ifid_pc_plus4_o, 32'd0);
        check("rst.misaligned", 32'(misaligned_o), 32'd0);
        check("rst.address", 32'(address_o), 32'd0);

        // Release: FIRST inserts a bubble, then words 1..3 stream out
        reset = 1'b1;
        step(NOP, 32'd0, 1'b0, 1'b0, B + 32'h4, 1'b0, 1'b0, "first_bubble");
        step(32'h22, B + 32'h4, 1'b1, 1'b1, B + 32'h8, 1'b0, 1'b0, "fetch_w1");

        // Stall at pc 0x00400008 for three cycles
        stall_i = 1'b1;
        repeat (3) step(32'h22, B + 32'h4, 1'b1, 1'b1, B + 32'h8, 1'b0, 1'b0, "stall_hold");
        stall_i = 1'b0;
        step(32'h33, B + 32'h8, 1'b1, 1'b1, B + 32'hC, 1'b0, 1'b0, "resume_w2");
        step(32'h44, B + 32'hC, 1'b1, 1'b1, B + 32'h10, 1'b0, 1'b0, "fetch_w3");
        step(32'h55, B + 32'h10, 1'b1, 1'b1, B + 32'h14, 1'b0, 1'b0, "fetch_w4");

        // Redirect + flush back to word 4
        redirect_i = 1'b1; flush_i = 1'b1; redirect_target_i = B + 32'h10;
        step(NOP, B + 32'h14, 1'b0, 1'b1, B + 32'h10, 1'b0, 1'b0, "redir_flush");
        redirect_i = 1'b0; flush_i = 1'b0;
        step(32'h55, B + 32'h10, 1'b1, 1'b1, B + 32'h14, 1'b0, 1'b0, "redir_target");

        // Misaligned redirect: target aligned down, one-cycle pulse, no implicit flush
        redirect_i = 1'b1; redirect_target_i = B + 32'h6;
        step(32'h1005, B + 32'h14, 1'b1, 1'b1, B + 32'h4, 1'b1, 1'b0, "misaligned");
        redirect_i = 1'b0;
        step(32'h22, B + 32'h4, 1'b1, 1'b1, B + 32'h8, 1'b0, 1'b0, "mis_pulse_end");

        // Last in-range word, then run off the window into HALT
        redirect_i = 1'b1; flush_i = 1'b1; redirect_target_i = B + 32'h7C;
        step(NOP, B + 32'h8, 1'b0, 1'b1, B + 32'h7C, 1'b0, 1'b0, "redir_last_word");
        check("last_word.address", 32'(address_o), 32'd31);
        redirect_i = 1'b0; flush_i = 1'b0;
        step(32'h101F, B + 32'h7C, 1'b1, 1'b1, B + 32'h80, 1'b0, 1'b1, "fetch_last_word");
        repeat (5) step(NOP, 32'd0, 1'b0, 1'b0, B + 32'h80, 1'b0, 1'b1, "halt_bubble");
        redirect_i = 1'b1; redirect_target_i = B;
        step(NOP, 32'd0, 1'b0, 1'b0, B, 1'b0, 1'b0, "halt_exit");
        redirect_i = 1'b0;
        step(32'h11, B, 1'b1, 1'b1, B + 32'h4, 1'b0, 1'b0, "resume_w0");

        // Below the ROM base is out of range; a redirect in that cycle recovers
        redirect_i = 1'b1; flush_i = 1'b1; redirect_target_i = 32'h003F_FFFC;
        step(NOP, B + 32'h4, 1'b0, 1'b1, 32'h003F_FFFC, 1'b0, 1'b1, "below_base");
        redirect_target_i = B;
        step(NOP, 32'h003F_FFFC, 1'b0, 1'b1, B, 1'b0, 1'b0, "below_base_recover");
        redirect_i = 1'b0; flush_i = 1'b0;
        step(32'h11, B, 1'b1, 1'b1, B + 32'h4, 1'b0, 1'b0, "refetch_w0");

        // Redirect beats stall on the PC; stall still holds IF/ID
        redirect_i = 1'b1; stall_i = 1'b1; redirect_target_i = B + 32'h8;
        step(32'h11, B, 1'b1, 1'b1, B + 32'h8, 1'b0, 1'b0, "redir_stall");
        redirect_i = 1'b0; stall_i = 1'b0;
        step(32'h33, B + 32'h8, 1'b1, 1'b1, B + 32'hC, 1'b0, 1'b0, "after_redir_stall");

        // Flush + stall: PC holds, IF/ID bubbles
        flush_i = 1'b1; stall_i = 1'b1;
        step(NOP, B + 32'hC, 1'b0, 1'b1, B + 32'hC, 1'b0, 1'b0, "flush_stall");
        flush_i = 1'b0; stall_i = 1'b0;
        step(32'h44, B + 32'hC, 1'b1, 1'b1, B + 32'h10, 1'b0, 1'b0, "after_flush_stall");

        // Asynchronous reset mid-stream aborts a pending redirect and stall
        stall_i = 1'b1; redirect_i = 1'b1; redirect_target_i = B + 32'h20;
        reset = 1'b0;
        #1;
        check("async_rst.pc_o", pc_o, B);
        check("async_rst.valid", 32'(ifid_valid_o), 32'd0);
        check("async_rst.instr", ifid_instruction_o, NOP);
        check("async_rst.ifid_pc", ifid_pc_o, 32'd0);
        stall_i = 1'b0; redirect_i = 1'b0;
        tick();
        reset = 1'b1;
        step(NOP, 32'd0, 1'b0, 1'b0, B + 32'h4, 1'b0, 1'b0, "reset_first");
        step(32'h22, B + 32'h4, 1'b1, 1'b1, B + 32'h8, 1'b0, 1'b0, "reset_refetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
